// File: rtl/data_ram_resp_pkg.sv
// Shared definitions for the data-memory responder: control-bit names,
// bus width, FSM state encoding and the address-legality check.
package data_ram_resp_pkg;

  localparam int RegBus = 32;

  localparam logic ChipEna  = 1'b1;
  localparam logic ChipDisa = 1'b0;
  localparam logic IsWrite  = 1'b1;
  localparam logic IsRead   = 1'b0;

  localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // A byte address is illegal when it is not word aligned or when it
  // points beyond the 2**addr_w word array.
  function automatic logic addr_is_bad(input logic [RegBus-1:0] addr,
                                       input int unsigned addr_w);
    return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 32'd2)) != 32'd0);
  endfunction

endpackage

// File: rtl/data_ram_resp_array.sv
// Single-port word array for the data-memory responder. Writes and reads
// are both synchronous; the read register is the responder's data_o, so it
// is reset to zero, can be cleared for failed reads, and otherwise holds.
module dram_array
  import data_ram_resp_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              re_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [RegBus-1:0] wdata_i,
  output logic [RegBus-1:0] rdata_o
);

  logic [RegBus-1:0] mem_q [2**ADDR_W];
  logic [RegBus-1:0] rdata_d;
  logic [RegBus-1:0] rdata_q;

  // Storage write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Next read-register value: reset/clear to zero, load on read, else hold.
  always_comb begin
    rdata_d = rdata_q;
    if (rst) begin
      rdata_d = ZeroWord;
    end else if (clr_i) begin
      rdata_d = ZeroWord;
    end else if (re_i) begin
      rdata_d = mem_q[addr_i];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read register.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram_resp.sv
// Data-memory responder at the far end of the load/store port. Accepts a
// request in IDLE, waits WAIT_CYCLES states in ACCESS, performs the word
// access on the edge into RESP and pulses ack_o for one cycle.
// Optional feature macro: DRAM_ERR_EN (adds err_o and rejects misaligned or
// out-of-range addresses instead of aliasing them).
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [RegBus-1:0] addr_i,
  input  logic [RegBus-1:0] data_i,
  output logic [RegBus-1:0] data_o,
  output logic              ack_o,
`ifdef DRAM_ERR_EN
  output logic              stall_o,
  output logic              err_o
`else
  output logic              stall_o
`endif
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [RegBus-1:0] wdata_q, wdata_d;
  logic              bad_q, bad_d;
  logic              ack_q, ack_d;

  logic              accept_s;
  logic              go_resp_s;
  logic              acc_bad_s;
  logic              req_we_s;
  logic              req_bad_s;
  logic [ADDR_W-1:0] req_word_s;
  logic [RegBus-1:0] req_wdata_s;
  logic              arr_we_s;
  logic              arr_re_s;
  logic              arr_clr_s;

`ifdef DRAM_ERR_EN
  logic              err_q, err_d;
  assign acc_bad_s = addr_is_bad(addr_i, ADDR_W);
`else
  logic              unused_addr_s;
  assign acc_bad_s     = 1'b0;
  assign unused_addr_s = ^{addr_i[RegBus-1:ADDR_W+2], addr_i[1:0]};
`endif

  // FSM state and wait counter register.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  // FSM next state: accept in IDLE, count down in ACCESS, single RESP cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (ce_i == ChipEna) begin
          if (WAIT_CYCLES > 0) begin
            state_d = ACCESS;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          state_d = ACCESS;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (rst) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else begin
      state_d = state_d;
    end
  end

  // FSM outputs: stall, and array controls. In IDLE the live inputs drive
  // the array so a zero-wait access can complete on the accepting edge.
  always_comb begin
    accept_s  = (state_q == IDLE) && (ce_i == ChipEna);
    go_resp_s = (state_d == RESP);
    if (state_q == IDLE) begin
      req_we_s    = we_i;
      req_word_s  = addr_i[ADDR_W+1:2];
      req_wdata_s = data_i;
      req_bad_s   = acc_bad_s;
    end else begin
      req_we_s    = we_q;
      req_word_s  = word_q;
      req_wdata_s = wdata_q;
      req_bad_s   = bad_q;
    end
    stall_o   = accept_s || (state_q == ACCESS);
    arr_we_s  = go_resp_s && (req_we_s == IsWrite) && !req_bad_s;
    arr_re_s  = go_resp_s && (req_we_s == IsRead) && !req_bad_s;
    arr_clr_s = go_resp_s && (req_we_s == IsRead) && req_bad_s;
  end

  // Request latches and response flags, next values.
  always_comb begin
    we_d    = we_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    bad_d   = bad_q;
    ack_d   = go_resp_s;
`ifdef DRAM_ERR_EN
    err_d   = go_resp_s && req_bad_s;
`endif
    if (rst) begin
      we_d    = IsRead;
      word_d  = '0;
      wdata_d = ZeroWord;
      bad_d   = 1'b0;
      ack_d   = 1'b0;
`ifdef DRAM_ERR_EN
      err_d   = 1'b0;
`endif
    end else if (accept_s) begin
      we_d    = we_i;
      word_d  = addr_i[ADDR_W+1:2];
      wdata_d = data_i;
      bad_d   = acc_bad_s;
    end else begin
      we_d    = we_q;
    end
  end

  // Request latches and response flag registers.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    word_q  <= word_d;
    wdata_q <= wdata_d;
    bad_q   <= bad_d;
    ack_q   <= ack_d;
`ifdef DRAM_ERR_EN
    err_q   <= err_d;
`endif
  end

  assign ack_o = ack_q;
`ifdef DRAM_ERR_EN
  assign err_o = err_q;
`endif

  dram_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (arr_we_s),
    .re_i    (arr_re_s),
    .clr_i   (arr_clr_s),
    .addr_i  (req_word_s),
    .wdata_i (req_wdata_s),
    .rdata_o (data_o)
  );

endmodule

// File: tb/tb_data_ram_resp.sv
// Self-checking bench for data_ram_resp: directed scenarios with literal
// expectations, then randomized traffic checked against a transaction-level
// model of the responder.
module tb_data_ram_resp;

  localparam int ADDR_W = 10;
  localparam int W      = 1;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic        stall_o;
`ifdef DRAM_ERR_EN
  logic        err_o;
`endif

  always #5 clk = ~clk;

  data_ram_resp #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .ce_i    (ce_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .data_o  (data_o),
    .ack_o   (ack_o),
`ifdef DRAM_ERR_EN
    .stall_o (stall_o),
    .err_o   (err_o)
`else
    .stall_o (stall_o)
`endif
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  bit          m_ready = 1'b0;
  bit          m_busy, m_inresp, m_we, m_err;
  int          m_edge = 0, m_resp_edge, m_word;
  logic [31:0] m_data;
  bit          exp_ack, exp_err, exp_known;
  logic [31:0] exp_data;

  function automatic bit addr_bad(input logic [31:0] a);
`ifdef DRAM_ERR_EN
    return ((a % 32'd4) != 32'd0) || ((a / 32'd4) >= 32'(DEPTH));
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    m_edge++;
    if (rst) begin
      m_busy = 0; m_inresp = 0; exp_ack = 0; exp_err = 0;
      exp_data = 32'd0; exp_known = 1; m_ready = 1;
    end else begin
      exp_ack = 0;
      exp_err = 0;
      if (m_inresp) begin
        m_inresp = 0;
      end else if (!m_busy && ce_i) begin
        m_busy      = 1;
        m_resp_edge = m_edge + W;
        m_we        = we_i;
        m_word      = int'((addr_i / 32'd4) % 32'(DEPTH));
        m_data      = data_i;
        m_err       = addr_bad(addr_i);
      end
      if (m_busy && m_edge == m_resp_edge) begin
        m_busy   = 0;
        m_inresp = 1;
        exp_ack  = 1;
        exp_err  = m_err;
        if (m_we) begin
          if (!m_err) begin
            m_mem[m_word]   = m_data;
            m_known[m_word] = 1;
          end
        end else if (m_err) begin
          exp_data  = 32'd0;
          exp_known = 1;
        end else begin
          exp_data  = m_mem[m_word];
          exp_known = m_known[m_word];
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Per-cycle comparison of all outputs against the model, 1 time unit
  // after the active edge.
  always @(posedge clk) begin
    #1;
    if (m_ready) begin
      chk("ack_o", {31'd0, ack_o}, {31'd0, exp_ack});
      chk("stall_o", {31'd0, stall_o}, {31'd0, (m_busy || (!m_inresp && ce_i))});
      if (exp_known) chk("data_o", data_o, exp_data);
`ifdef DRAM_ERR_EN
      chk("err_o", {31'd0, err_o}, {31'd0, exp_err});
`endif
    end
  end

  // ---------------- directed helpers ----------------
  // Called at a falling edge; issues a request and waits for its ack.
  task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, input bit chk_stall,
                        output logic [31:0] rd, output bit er);
    int n;
    bit got;
    ce_i = 1'b1; we_i = we; addr_i = a; data_i = d;
    if (chk_stall) begin
      #1;
      chk("stall_accept", {31'd0, stall_o}, 32'd1);
    end
    n = 0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      n++;
      if (ack_o) got = 1;
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
    chk("ack_latency", 32'(n), 32'(exp_lat));
    rd = data_o;
`ifdef DRAM_ERR_EN
    er = err_o;
`else
    er = 1'b0;
`endif
    ce_i = 1'b0;
  endtask

  task automatic req_idle(input bit we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output bit er);
    @(negedge clk);
    do_req(we, a, d, 1 + W, 1'b1, rd, er);
  endtask

  logic [31:0] rd;
  bit          er;
  logic [31:0] word_r, upper_r, low_r;

  initial begin
    rst = 1'b1; ce_i = 1'b0; we_i = 1'b0; addr_i = 32'd0; data_i = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_data", data_o, 32'd0);
    chk("reset_ack", {31'd0, ack_o}, 32'd0);
    chk("reset_stall", {31'd0, stall_o}, 32'd0);

    // Write then read back.
    req_idle(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, er);
    req_idle(1'b0, 32'h0000_0010, 32'd0, rd, er);
    chk("rd_0x10", rd, 32'hDEAD_BEEF);

    // Unwritten word, then written, then read.
    req_idle(1'b0, 32'h0000_0004, 32'd0, rd, er);
    req_idle(1'b1, 32'h0000_0004, 32'hCAFE_0004, rd, er);
    req_idle(1'b0, 32'h0000_0004, 32'd0, rd, er);
    chk("rd_0x4", rd, 32'hCAFE_0004);

    // Back-to-back with ce held: second accept in the IDLE after RESP.
    req_idle(1'b1, 32'h0000_0008, 32'h1111_1111, rd, er);
    do_req(1'b0, 32'h0000_0008, 32'd0, 2 + W, 1'b0, rd, er);
    chk("b2b_rd_0x8", rd, 32'h1111_1111);

    // Reset during ACCESS aborts the pending write.
    req_idle(1'b1, 32'h0000_0020, 32'h0BAD_F00D, rd, er);
    @(negedge clk);
    ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0020; data_i = 32'hA5A5_A5A5;
    @(negedge clk);
    rst = 1'b1; ce_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_data", data_o, 32'd0);
    chk("abort_ack", {31'd0, ack_o}, 32'd0);
    req_idle(1'b0, 32'h0000_0020, 32'd0, rd, er);
    chk("rd_0x20_prior", rd, 32'h0BAD_F00D);

    // Aliasing / error handling of out-of-range and misaligned addresses.
    req_idle(1'b1, 32'h0000_0000, 32'h0000_5555, rd, er);
`ifdef DRAM_ERR_EN
    req_idle(1'b1, 32'h0000_1000, 32'h0000_1234, rd, er);
    chk("err_wr_0x1000", {31'd0, er}, 32'd1);
    req_idle(1'b0, 32'h0000_0000, 32'd0, rd, er);
    chk("rd_0x0_kept", rd, 32'h0000_5555);
    chk("err_rd_0x0", {31'd0, er}, 32'd0);
    req_idle(1'b0, 32'h0000_0003, 32'd0, rd, er);
    chk("err_rd_0x3", {31'd0, er}, 32'd1);
    chk("err_rd_data", rd, 32'd0);
`else
    req_idle(1'b1, 32'h0000_1000, 32'h0000_1234, rd, er);
    req_idle(1'b0, 32'h0000_0000, 32'd0, rd, er);
    chk("alias_rd_0x0", rd, 32'h0000_1234);
    req_idle(1'b0, 32'h0000_0013, 32'd0, rd, er);
    chk("lowbits_rd_0x13", rd, 32'hDEAD_BEEF);
`endif

    // Randomized traffic; inputs held while the DUT stalls.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        ce_i = 1'b0;
      end else if (!stall_o) begin
        ce_i    = ($urandom_range(0, 3) != 0);
        we_i    = 1'($urandom_range(0, 1));
        word_r  = 32'($urandom_range(0, 15));
        upper_r = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 255)) : 32'd0;
        low_r   = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0;
        addr_i  = (upper_r << (ADDR_W + 2)) | (word_r << 2) | low_r;
        data_i  = $urandom;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    ce_i = 1'b0;
    repeat (6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
